mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised successor to the two-client (instruction fetch plus data) memory controller.
- Arbitrates NUM_PORTS request ports onto the single byte-serial external memory bus.
- Supports 1/2/4-byte reads and writes, fixed-priority or round-robin arbitration, a UART back-pressure stall and an rdy pause.
- Sits between the fetch/LSU/cache clients and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- NUM_PORTS, 2, number of client ports; port 0 has highest fixed priority.
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin.
- ADDR_W, 32, address width; only [17:0] is meaningful to memory.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  high = run; low = pause
- req_valid  in  NUM_PORTS  per-port request
- req_we  in  NUM_PORTS  1 = write
- req_size  in  2*NUM_PORTS  0 = byte, 1 = half, 2 = word, 3 = word
- req_addr  in  ADDR_W*NUM_PORTS  start byte address
- req_wdata  in  32*NUM_PORTS  write data, little-endian
- req_ready  out  NUM_PORTS  one-hot grant; request accepted this cycle
- resp_valid  out  NUM_PORTS  one-cycle completion pulse
- resp_rdata  out  32  read data, zero-extended, shared by all ports
- mem_din  in  8  read byte, valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, all req_ready and resp_valid 0, resp_rdata 0, mem_a 0, mem_dout 0, mem_wr 0, round-robin pointer 0.
- Reset mid-transfer: the transfer is aborted, no resp_valid is produced, and the bus is idle in the following cycle.
- Idle bus: mem_a 0, mem_wr 0, mem_dout 0. An IO address is never presented except for an active transfer.
- FSM states: IDLE, XFER, TAIL, DONE.
- IDLE:
  - If any req_valid is set and rdy is 1, grant exactly one port combinationally; req_ready[g] = 1 in cycle T.
  - Latch addr, size, we and wdata; nbytes = 1/2/4; go to XFER.
  - Clients hold their request stable until req_ready.
- XFER: in cycle T+1+i drive mem_a = addr+i (modulo 2^ADDR_W), for i = 0..nbytes-1.
  - Writes: mem_wr = 1, mem_dout = wdata[8i+7:8i].
  - Reads: mem_wr = 0. Byte i arrives on mem_din in cycle T+2+i and is stored to rdata[8i+7:8i].
- XFER exit: after the last byte, writes go to DONE and reads go to TAIL.
- TAIL: bus idle; capture the last byte; go to DONE.
- DONE: resp_valid[g] = 1 for one cycle with resp_rdata valid; go to IDLE. No grant is issued in DONE.
- Latency:
  - Word read: accept T, resp T+6; byte read T+3.
  - Word write: resp T+5; byte write T+2.
  - Back-to-back throughput: read nbytes+3 cycles, write nbytes+2 cycles.
- IO stall: if addr+i has [17:16] == 2'b11, we = 1 and io_buffer_full = 1, then hold byte i with mem_wr = 0 until io_buffer_full = 0.
- rdy low:
  - Freezes state, counters and the round-robin pointer; mem_wr forced 0; mem_a = 0; no grant.
  - Read capture is NOT gated by rdy: a byte issued in the cycle before the pause is still captured, and no byte is ever re-issued. This makes 0x30000 reads exactly-once.
  - If rdy drops in DONE, the resp_valid pulse is held until rdy returns and asserts exactly once.
- Arbitration:
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at ptr; after a grant to port g, ptr = (g+1) mod NUM_PORTS.
  - Ports not granted keep their req_valid asserted and are not acknowledged.
- Misaligned and page-crossing accesses are legal; bytes are sequential.
- Size 3 is treated as word.

Decomposition:
- Package mem_arb_pkg: size encodings, FSM state encodings, IO_REGION = 2'b11 at bits [17:16], BYTE_W = 8.
- Sub-module rr_arbiter (parameter NUM_PORTS, MODE): req vector and ptr in, one-hot grant out, combinational only.
- FSM, byte counter and data assembly stay in mem_arbiter.

Test Plan:
- Port 0 word read at 0x00100, memory 0x100..0x103 = 11 22 33 44 -> mem_a 0x100..0x103 on T+1..T+4, resp_valid[0] at T+6, resp_rdata 0x44332211.
- Port 1 half write 0xBEEF at 0x001FF -> mem_a 0x1FF/0x200, mem_dout EF/BE, mem_wr 1 on T+1..T+2, resp_valid[1] at T+3.
- Ports 0 and 1 request continuously, ARB_MODE=1 -> grants alternate 0,1,0,1; with ARB_MODE=0 port 0 always wins and port 1 starves.
- Byte write 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr 0 for those 5 cycles; exactly one mem_wr = 1 cycle with mem_dout 0x41 after it clears.
- Word read with rdy low for 3 cycles after byte 1 is issued -> byte 1 still captured; mem_a resumes at addr+2; no repeated address; correct rdata.
- rst asserted at byte 2 of a word write -> no further mem_wr; bus idle next cycle; no resp_valid; new request accepted normally afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the multi-port byte-serial memory arbiter.
package mem_arb_pkg;
   localparam int         BYTE_W    = 8;
   localparam logic [1:0] IO_REGION = 2'b11;

   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_WORD3 = 2'd3} size_e;
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, TAIL = 2'd2, DONE = 2'd3} state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  last;
      logic [31:0] wdata;
   } xfer_t;

   // Index of the final byte of a transfer; size 3 behaves as a word.
   function automatic logic [1:0] last_idx(input logic [1:0] size);
      case (size_e'(size))
         SZ_BYTE: return 2'd0;
         SZ_HALF: return 2'd1;
         default: return 2'd3;
      endcase
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: fixed priority (MODE 0) or rotating from ptr (MODE 1).
module rr_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int MODE      = 0,
   parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] gnt
);
   logic [PTR_W-1:0]     sh;
   logic [NUM_PORTS-1:0] rot;
   logic [NUM_PORTS-1:0] first;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
   assign sh    = (MODE != 0) ? ptr : '0;
   assign rot   = NUM_PORTS'({req, req} >> sh);
   assign first = rot & (~rot + NUM_PORTS'(1));
   assign gnt   = NUM_PORTS'({first, first} << sh >> NUM_PORTS);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_PORTS clients onto the byte-serial external memory bus,
// one transfer at a time, with IO back-pressure and an rdy pause.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ARB_MODE  = 0,
   parameter int ADDR_W    = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rdy,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS-1:0][1:0]        req_size,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS-1:0][31:0]       req_wdata,
   output logic [NUM_PORTS-1:0]             req_ready,
   output logic [NUM_PORTS-1:0]             resp_valid,
   output logic [31:0]                      resp_rdata,
   input  logic [7:0]                       mem_din,
   output logic [7:0]                       mem_dout,
   output logic [31:0]                      mem_a,
   output logic                             mem_wr,
   input  logic                             io_buffer_full
);
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   state_e               state_q, state_d;
   logic [NUM_PORTS-1:0] port_q, port_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d, gidx;
   logic [ADDR_W-1:0]    addr_q, addr_d, sel_addr, cur_addr;
   xfer_t                xfer_q, xfer_d;
   logic [1:0]           cnt_q, cnt_d, cap_idx_q, cap_idx_d, sel_size;
   logic [31:0]          rdata_q, rdata_d, sel_wdata;
   logic                 cap_q, cap_d, sel_we;
   logic [NUM_PORTS-1:0] arb_req, gnt;
   logic                 run, stall, issue, in_xfer;

   assign run      = rdy & ~rst;
   assign arb_req  = (state_q == IDLE && run) ? req_valid : '0;
   assign cur_addr = addr_q + ADDR_W'(cnt_q);
   assign stall    = xfer_q.we & io_buffer_full & (cur_addr[17:16] == IO_REGION);
   assign in_xfer  = (state_q == XFER) & run;
   assign issue    = in_xfer & ~stall;

   rr_arbiter #(.NUM_PORTS(NUM_PORTS), .MODE(ARB_MODE), .PTR_W(PTR_W)) u_arb (
      .req(arb_req), .ptr(ptr_q), .gnt(gnt)
   );

   always_comb begin
      sel_addr  = '0;
      sel_we    = 1'b0;
      sel_size  = '0;
      sel_wdata = '0;
      gidx      = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt[p]) begin
            sel_addr  = req_addr[p];
            sel_we    = req_we[p];
            sel_size  = req_size[p];
            sel_wdata = req_wdata[p];
            gidx      = PTR_W'(p);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      xfer_d    = xfer_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      // A read byte lands the cycle after it is issued, whatever rdy does then.
      cap_d     = issue & ~xfer_q.we;
      cap_idx_d = cnt_q;
      if (cap_q) rdata_d[BYTE_W*cap_idx_q +: BYTE_W] = mem_din;
      case (state_q)
         IDLE: if (|gnt) begin
            port_d  = gnt;
            addr_d  = sel_addr;
            xfer_d  = '{we: sel_we, last: last_idx(sel_size), wdata: sel_wdata};
            cnt_d   = '0;
            rdata_d = '0;
            ptr_d   = (gidx == PTR_W'(NUM_PORTS-1)) ? '0 : gidx + PTR_W'(1);
            state_d = XFER;
         end
         XFER: if (issue) begin
            if (cnt_q == xfer_q.last) state_d = xfer_q.we ? DONE : TAIL;
            else                      cnt_d   = cnt_q + 2'd1;
         end
         TAIL:    if (run) state_d = DONE;
         default: if (run) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         port_q    <= '0;
         ptr_q     <= '0;
         addr_q    <= '0;
         xfer_q    <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         cap_q     <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         xfer_q    <= xfer_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         cap_q     <= cap_d;
         cap_idx_q <= cap_idx_d;
      end
   end

   assign req_ready  = gnt;
   assign resp_valid = (state_q == DONE && run) ? port_q : '0;
   assign resp_rdata = rdata_q;
   assign mem_a      = in_xfer ? 32'(cur_addr) : '0;
   assign mem_wr     = issue & xfer_q.we;
   assign mem_dout   = (in_xfer && xfer_q.we) ? xfer_q.wdata[BYTE_W*cnt_q +: BYTE_W] : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transfers checked against a per-transaction timing/data model.
module tb_mem_arbiter;
   logic             clk = 1'b0;
   logic             rst, rdy, io_buffer_full;
   logic [1:0]       req_valid, fp_req_valid, req_we;
   logic [1:0][1:0]  req_size;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [1:0]       req_ready, resp_valid, fp_req_ready, fp_resp_valid;
   logic [31:0]      resp_rdata, mem_a, fp_rdata, fp_mem_a;
   logic [7:0]       mem_din, mem_dout, fp_dout;
   logic             mem_wr, fp_wr;

   int vectors = 0, errors = 0;
   logic [7:0]  ref_mem [logic [31:0]];
   logic [31:0] lg_a [0:63];
   logic        lg_wr [0:63];
   logic [7:0]  lg_dout [0:63];
   int          acc_k, resp_k;
   logic [31:0] got_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(1), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0), .ADDR_W(32)) dut_fp (
      .clk(clk), .rst(rst), .rdy(rdy), .req_valid(fp_req_valid), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(fp_req_ready), .resp_valid(fp_resp_valid), .resp_rdata(fp_rdata),
      .mem_din(mem_din), .mem_dout(fp_dout), .mem_a(fp_mem_a), .mem_wr(fp_wr),
      .io_buffer_full(io_buffer_full)
   );

   // External memory contents: preloaded bytes, otherwise a fixed address pattern.
   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   always @(posedge clk) mem_din <= ref_byte(mem_a);

   // Raise a request on port p and wait for its grant; returns at T+1 (+1 time unit).
   task automatic issue_req(input int p, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
      req_valid = '0;
      req_we[p] = we; req_size[p] = sz; req_addr[p] = a; req_wdata[p] = wd;
      req_valid[p] = 1'b1;
      acc_k = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (req_ready[p]) begin acc_k = c; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
   endtask

   // Full transfer with a bus log of cycles T+1.. up to the response.
   task automatic run_xfer(input int p, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
      issue_req(p, we, sz, a, wd);
      resp_k = -1;
      got_rdata = '0;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         lg_a[k] = mem_a; lg_wr[k] = mem_wr; lg_dout[k] = mem_dout;
         if (resp_valid[p]) begin resp_k = k; got_rdata = resp_rdata; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
      req_valid = 2'b11; fp_req_valid = 2'b11;
      req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (req_ready !== 2'b00 || fp_req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b/%b want 00", req_ready, fp_req_ready); end
      vectors++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
      vectors++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
      vectors++; if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_bus got a=%h d=%h wr=%b want idle", mem_a, mem_dout, mem_wr); end
      @(posedge clk); #1;
      rst = 1'b0; req_valid = '0; fp_req_valid = '0;
   endtask

   task automatic test_word_read();
      ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22;
      ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
      run_xfer(0, 1'b0, 2'd2, 32'h100, 32'h0);
      vectors++; if (acc_k != 0) begin errors++; $display("FAIL word_read_accept got %0d want 0", acc_k); end
      for (int k = 1; k <= 4; k++) begin
         vectors++; if (lg_a[k] !== 32'h100 + k - 1 || lg_wr[k] !== 1'b0) begin errors++; $display("FAIL word_read_bus k=%0d got a=%h wr=%b want a=%h wr=0", k, lg_a[k], lg_wr[k], 32'h100 + k - 1); end
      end
      vectors++; if (lg_a[5] !== 32'h0) begin errors++; $display("FAIL word_read_tail got a=%h want 0", lg_a[5]); end
      vectors++; if (resp_k != 6) begin errors++; $display("FAIL word_read_latency got %0d want 6", resp_k); end
      vectors++; if (got_rdata !== 32'h44332211) begin errors++; $display("FAIL word_read_data got %h want 44332211", got_rdata); end
   endtask

   task automatic test_half_write();
      logic [31:0] exp;
      run_xfer(1, 1'b1, 2'd1, 32'h1FF, 32'h0000BEEF);
      vectors++; if (lg_a[1] !== 32'h1FF || lg_wr[1] !== 1'b1 || lg_dout[1] !== 8'hEF) begin errors++; $display("FAIL half_write_b0 got a=%h wr=%b d=%h want 1ff 1 ef", lg_a[1], lg_wr[1], lg_dout[1]); end
      vectors++; if (lg_a[2] !== 32'h200 || lg_wr[2] !== 1'b1 || lg_dout[2] !== 8'hBE) begin errors++; $display("FAIL half_write_b1 got a=%h wr=%b d=%h want 200 1 be", lg_a[2], lg_wr[2], lg_dout[2]); end
      vectors++; if (resp_k != 3) begin errors++; $display("FAIL half_write_latency got %0d want 3", resp_k); end
      // Half read across the page boundary must come back zero-extended.
      exp = {16'h0, ref_byte(32'h200), ref_byte(32'h1FF)};
      run_xfer(1, 1'b0, 2'd1, 32'h1FF, 32'h0);
      vectors++; if (resp_k != 4 || got_rdata !== exp) begin errors++; $display("FAIL half_read got lat=%0d d=%h want lat=4 d=%h", resp_k, got_rdata, exp); end
   endtask

   task automatic test_round_robin();
      int g[$];
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      req_we = '0; req_size = '0; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
      req_valid = 2'b11;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready == 2'b01) g.push_back(0);
         else if (req_ready == 2'b10) g.push_back(1);
         else if (req_ready != 2'b00) g.push_back(9);
         @(posedge clk); #1;
      end
      req_valid = '0;
      repeat (6) @(posedge clk); #1;
      vectors++; if (g.size() != 10) begin errors++; $display("FAIL rr_grant_count got %0d want 10", g.size()); end
      foreach (g[i]) begin
         vectors++; if (g[i] != i % 2) begin errors++; $display("FAIL rr_order idx=%0d got %0d want %0d", i, g[i], i % 2); end
      end
   endtask

   task automatic test_fixed_priority();
      int n0, n1;
      n0 = 0; n1 = 0;
      req_we = '0; req_size[0] = 2'd2; req_size[1] = 2'd2;
      fp_req_valid = 2'b11;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (fp_req_ready[0]) n0++;
         if (fp_req_ready[1]) n1++;
         @(posedge clk); #1;
      end
      fp_req_valid = '0;
      repeat (8) @(posedge clk); #1;
      vectors++; if (n0 != 6) begin errors++; $display("FAIL fixed_port0_grants got %0d want 6", n0); end
      vectors++; if (n1 != 0) begin errors++; $display("FAIL fixed_port1_starve got %0d want 0", n1); end
   endtask

   task automatic test_io_stall();
      int wr_n, rk;
      wr_n = 0; rk = -1;
      io_buffer_full = 1'b1;
      issue_req(0, 1'b1, 2'd0, 32'h30000, 32'h41);
      vectors++; if (acc_k != 0) begin errors++; $display("FAIL io_accept got %0d want 0", acc_k); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k <= 5) begin
            vectors++; if (mem_wr !== 1'b0 || mem_a !== 32'h30000) begin errors++; $display("FAIL io_hold k=%0d got wr=%b a=%h want wr=0 a=30000", k, mem_wr, mem_a); end
         end
         if (mem_wr === 1'b1) begin
            wr_n++;
            vectors++; if (k != 6 || mem_dout !== 8'h41 || mem_a !== 32'h30000) begin errors++; $display("FAIL io_write k=%0d got d=%h a=%h want k=6 d=41 a=30000", k, mem_dout, mem_a); end
         end
         if (resp_valid[0] && rk < 0) rk = k;
         @(posedge clk); #1;
         if (k == 5) io_buffer_full = 1'b0;
      end
      vectors++; if (wr_n != 1) begin errors++; $display("FAIL io_write_count got %0d want 1", wr_n); end
      vectors++; if (rk != 7) begin errors++; $display("FAIL io_latency got %0d want 7", rk); end
   endtask

   task automatic test_rdy_pause();
      logic [31:0] seen[$];
      logic [31:0] a, exp, rd;
      int rk;
      a = 32'h4000; rk = -1; rd = '0;
      for (int j = 0; j < 4; j++) exp[8*j +: 8] = ref_byte(a + j);
      issue_req(0, 1'b0, 2'd2, a, 32'h0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (mem_a !== 32'h0) seen.push_back(mem_a);
         if (k >= 3 && k <= 5) begin
            vectors++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rdy_pause_bus k=%0d got a=%h wr=%b want idle", k, mem_a, mem_wr); end
         end
         if (resp_valid[0] && rk < 0) begin rk = k; rd = resp_rdata; end
         @(posedge clk); #1;
         if (k == 2) rdy = 1'b0;
         if (k == 5) rdy = 1'b1;
      end
      vectors++; if (seen.size() != 4) begin errors++; $display("FAIL rdy_addr_count got %0d want 4", seen.size()); end
      foreach (seen[j]) begin
         vectors++; if (seen[j] !== a + j) begin errors++; $display("FAIL rdy_addr j=%0d got %h want %h", j, seen[j], a + j); end
      end
      vectors++; if (rk != 9) begin errors++; $display("FAIL rdy_latency got %0d want 9", rk); end
      vectors++; if (rd !== exp) begin errors++; $display("FAIL rdy_data got %h want %h", rd, exp); end
   endtask

   task automatic test_rdy_done();
      int rn, rk;
      rn = 0; rk = -1;
      issue_req(1, 1'b1, 2'd0, 32'h500, 32'h7E);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            vectors++; if (mem_a !== 32'h500 || mem_wr !== 1'b1 || mem_dout !== 8'h7E) begin errors++; $display("FAIL rdy_done_write got a=%h wr=%b d=%h want 500 1 7e", mem_a, mem_wr, mem_dout); end
         end
         if (resp_valid[1]) begin rn++; if (rk < 0) rk = k; end
         @(posedge clk); #1;
         if (k == 1) rdy = 1'b0;
         if (k == 3) rdy = 1'b1;
      end
      vectors++; if (rn != 1 || rk != 4) begin errors++; $display("FAIL rdy_done_resp got count=%0d k=%0d want count=1 k=4", rn, rk); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int p, n;
         logic we;
         logic [1:0] sz;
         logic [31:0] a, wd, exp;
         p  = $urandom_range(0, 1);
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = (i == 0) ? 32'hFFFF_FFFE : (i == 1) ? 32'h0000_FFFF : 32'($urandom_range(0, 32'h2FFFF));
         wd = $urandom;
         n  = nbytes(sz);
         exp = '0;
         for (int j = 0; j < n; j++) exp[8*j +: 8] = ref_byte(a + j);
         run_xfer(p, we, sz, a, wd);
         vectors++; if (acc_k != 0 || resp_k != (we ? n + 1 : n + 2)) begin errors++; $display("FAIL rand_timing i=%0d got acc=%0d lat=%0d want acc=0 lat=%0d", i, acc_k, resp_k, we ? n + 1 : n + 2); end
         for (int k = 1; k <= n; k++) begin
            vectors++;
            if (lg_a[k] !== a + k - 1 || lg_wr[k] !== we || lg_dout[k] !== (we ? wd[8*(k-1) +: 8] : 8'h0)) begin
               errors++;
               $display("FAIL rand_bus i=%0d k=%0d got a=%h wr=%b d=%h want a=%h wr=%b d=%h", i, k, lg_a[k], lg_wr[k], lg_dout[k], a + k - 1, we, we ? wd[8*(k-1) +: 8] : 8'h0);
            end
         end
         if (!we) begin
            vectors++; if (got_rdata !== exp) begin errors++; $display("FAIL rand_rdata i=%0d got %h want %h", i, got_rdata, exp); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp;
      int bad_wr, bad_rv, bad_a;
      bad_wr = 0; bad_rv = 0; bad_a = 0;
      issue_req(0, 1'b1, 2'd2, 32'h600, 32'hA1B2C3D4);
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 4; k <= 11; k++) begin
         @(negedge clk);
         if (mem_wr !== 1'b0) bad_wr++;
         if (resp_valid !== 2'b00) bad_rv++;
         if (mem_a !== 32'h0) bad_a++;
         @(posedge clk); #1;
      end
      vectors++; if (bad_wr != 0) begin errors++; $display("FAIL rst_mid_wr got %0d cycles want 0", bad_wr); end
      vectors++; if (bad_rv != 0) begin errors++; $display("FAIL rst_mid_resp got %0d cycles want 0", bad_rv); end
      vectors++; if (bad_a != 0) begin errors++; $display("FAIL rst_mid_bus got %0d cycles want 0", bad_a); end
      for (int j = 0; j < 4; j++) exp[8*j +: 8] = ref_byte(32'h700 + j);
      run_xfer(1, 1'b0, 2'd2, 32'h700, 32'h0);
      vectors++; if (acc_k != 0 || resp_k != 6 || got_rdata !== exp) begin errors++; $display("FAIL rst_mid_after got acc=%0d lat=%0d d=%h want 0 6 %h", acc_k, resp_k, got_rdata, exp); end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_half_write();
      test_round_robin();
      test_fixed_priority();
      test_io_stall();
      test_rdy_pause();
      test_rdy_done();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
